// File: rtl/spi_tx_if.sv
// Byte-FIFO pop handshake and SPI mode-0 pins for the spi_tx transmitter.
interface spi_tx_if;
    // Handshake: rx_ready pulses for one cycle only after fifo_e was seen low; the FIFO
    // presents the popped byte on rx_data no later than the cycle after that pulse.
    logic       enable;
    logic       fifo_e;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_cs_n;
    logic       busy;
    logic       byte_done;

    modport master (
        input  enable, fifo_e, rx_data,
        output rx_ready, spi_sclk, spi_mosi, spi_cs_n, busy, byte_done
    );

    modport slave (
        output enable, fifo_e, rx_data,
        input  rx_ready, spi_sclk, spi_mosi, spi_cs_n, busy, byte_done
    );
endinterface

// File: rtl/spi_tx.sv
// SPI mode-0 byte transmitter: pops one byte per frame from a FIFO and shifts it out MSB first.
module spi_tx #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    spi_tx_if.master   bus,
    output logic [2:0] state_dbg
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        LOAD  = 3'd2,
        SHIFT = 3'd3,
        GAP   = 3'd4
    } state_t;

    localparam logic [7:0] DIV_TC = 8'(CLK_DIV - 1);

    state_t     state, state_d;
    logic [7:0] div_cnt, div_d;
    logic [2:0] bit_cnt, bit_d;
    logic [7:0] shreg, sh_d;
    logic       sclk_q, sclk_d;
    logic       armed;
    logic       tc;

    assign tc = (div_cnt == DIV_TC);

    // armed keeps the first POP off the first rising edge after reset release.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            div_cnt <= 8'd0;
            bit_cnt <= 3'd0;
            shreg   <= 8'd0;
            sclk_q  <= 1'b0;
            armed   <= 1'b0;
        end else begin
            state   <= state_d;
            div_cnt <= div_d;
            bit_cnt <= bit_d;
            shreg   <= sh_d;
            sclk_q  <= sclk_d;
            armed   <= 1'b1;
        end
    end

    always_comb begin
        state_d = state;
        div_d   = div_cnt;
        bit_d   = bit_cnt;
        sh_d    = shreg;
        sclk_d  = sclk_q;
        case (state)
            IDLE: begin
                if (armed && bus.enable && !bus.fifo_e) state_d = POP;
            end
            POP: state_d = LOAD;
            LOAD: begin
                sh_d    = bus.rx_data;
                div_d   = 8'd0;
                bit_d   = 3'd0;
                sclk_d  = 1'b0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (tc) begin
                    div_d  = 8'd0;
                    sclk_d = !sclk_q;
                    // Only the falling toggle advances data; the rising toggle is the sample point.
                    if (sclk_q) begin
                        bit_d = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state_d = GAP;
                        else                 sh_d = {shreg[6:0], 1'b0};
                    end
                end else begin
                    div_d = div_cnt + 8'd1;
                end
            end
            GAP: begin
                if (tc) begin
                    div_d   = 8'd0;
                    state_d = IDLE;
                end else begin
                    div_d = div_cnt + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rx_ready  = (state == POP);
    assign bus.spi_cs_n  = (state != SHIFT);
    assign bus.spi_mosi  = (state == SHIFT) && shreg[7];
    assign bus.spi_sclk  = sclk_q;
    assign bus.busy      = (state != IDLE);
    assign bus.byte_done = (state == GAP) && (div_cnt == 8'd0);
    assign state_dbg     = state;
endmodule
